// File: rtl/signed_sat_pkg.sv
// rtl/signed_sat_pkg.sv - shared signed saturation limits and clamp helper
package signed_sat_pkg;

   typedef struct packed {
      logic   sat;
      longint diff;
   } clamp_t;

   function automatic longint sat_max(input int width);
      return (longint'(1) <<< (width - 1)) - longint'(1);
   endfunction

   function automatic longint sat_min(input int width);
      return -(longint'(1) <<< (width - 1));
   endfunction

   // The caller sign-extends its wide value into a longint; the low width bits of diff are the result.
   function automatic clamp_t sat_clamp(input longint wide, input int width);
      clamp_t r;
      if (wide > sat_max(width)) begin
         r.sat  = 1'b1;
         r.diff = sat_max(width);
      end else if (wide < sat_min(width)) begin
         r.sat  = 1'b1;
         r.diff = sat_min(width);
      end else begin
         r.sat  = 1'b0;
         r.diff = wide;
      end
      return r;
   endfunction

endpackage

// File: rtl/pipe_stage_rv.sv
// rtl/pipe_stage_rv.sv - single valid/ready register slice with parameterised payload
module pipe_stage_rv #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (in_valid && in_ready) begin
         out_valid <= 1'b1;
         out_data  <= in_data;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/signed_sub_with_saturation_pipe.sv
// rtl/signed_sub_with_saturation_pipe.sv - two-stage saturating signed subtractor with valid/ready
// Optional saturation-event counter enabled by SIGNED_SUB_SAT_COUNT_EN.
module signed_sub_with_saturation_pipe
   import signed_sat_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    up_valid,
   output logic                    up_ready,
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic                    down_valid,
   input  logic                    down_ready,
   output logic signed [WIDTH-1:0] diff,
   output logic                    sat
`ifdef SIGNED_SUB_SAT_COUNT_EN
   ,
   output logic [CNT_W-1:0]        sat_count
`endif
);

   logic             s1_valid;
   logic             s1_ready;
   logic [WIDTH:0]   wide_in;
   logic [WIDTH:0]   s1_wide;
   logic [WIDTH:0]   s2_in;
   logic [WIDTH:0]   s2_out;
   clamp_t           clamp_res;

   // One extra bit holds any difference of two WIDTH-bit operands exactly.
   assign wide_in = {a[WIDTH-1], a} - {b[WIDTH-1], b};

   pipe_stage_rv #(.W(WIDTH + 1)) u_s1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (up_valid),
      .in_ready  (up_ready),
      .in_data   (wide_in),
      .out_valid (s1_valid),
      .out_ready (s1_ready),
      .out_data  (s1_wide)
   );

   always_comb begin
      clamp_res = sat_clamp(longint'($signed(s1_wide)), WIDTH);
      s2_in     = {clamp_res.sat, clamp_res.diff[WIDTH-1:0]};
   end

   pipe_stage_rv #(.W(WIDTH + 1)) u_s2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (s1_valid),
      .in_ready  (s1_ready),
      .in_data   (s2_in),
      .out_valid (down_valid),
      .out_ready (down_ready),
      .out_data  (s2_out)
   );

   assign sat  = s2_out[WIDTH];
   assign diff = s2_out[WIDTH-1:0];

`ifdef SIGNED_SUB_SAT_COUNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_count <= '0;
      end else if (down_valid && down_ready && sat && (sat_count != '1)) begin
         sat_count <= sat_count + CNT_W'(1);
      end
   end
`else
   // Keeps CNT_W referenced when the counter is compiled out.
   logic [CNT_W-1:0] unused_cnt_w;
   assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_signed_sub_with_saturation_pipe.sv
// tb/tb_signed_sub_with_saturation_pipe.sv - self-checking bench for signed_sub_with_saturation_pipe
module tb_signed_sub_with_saturation_pipe;

   localparam int W    = 4;
   localparam int MAXV = 7;
   localparam int MINV = -8;

   logic clk = 1'b0;
   logic rst_n;
   logic up_valid, up_ready, down_valid, down_ready, sat;
   logic signed [W-1:0] a, b, diff;
`ifdef SIGNED_SUB_SAT_COUNT_EN
   logic [1:0] sat_count;
`endif

   always #5 clk = ~clk;

   signed_sub_with_saturation_pipe #(.WIDTH(W), .CNT_W(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .up_valid   (up_valid),
      .up_ready   (up_ready),
      .a          (a),
      .b          (b),
      .down_valid (down_valid),
      .down_ready (down_ready),
      .diff       (diff),
      .sat        (sat)
`ifdef SIGNED_SUB_SAT_COUNT_EN
      ,
      .sat_count  (sat_count)
`endif
   );

   typedef struct { int a; int b; int d; int s; } vec_t;
   typedef struct { int d; int s; } res_t;

   int   checks = 0;
   int   failures = 0;
   res_t q[$];
   int   accepted = 0;
   int   emitted = 0;
   logic hold = 1'b0;
   int   hold_d, hold_s;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic res_t model(input int x, input int y);
      res_t r;
      int   d;
      d = x - y;
      if (d > MAXV) begin r.d = MAXV; r.s = 1; end
      else if (d < MINV) begin r.d = MINV; r.s = 1; end
      else begin r.d = d; r.s = 0; end
      return r;
   endfunction

   // One cycle of scoreboard accounting; inputs must be set before the call.
   task automatic tick();
      res_t r;
      @(negedge clk);
      if (rst_n) begin
         chk("up_ready_rule", int'(up_ready), (q.size() < 2 || down_ready) ? 1 : 0);
         if (hold) begin
            chk("hold_valid", int'(down_valid), 1);
            chk("hold_diff", int'(diff), hold_d);
            chk("hold_sat", int'(sat), hold_s);
         end
         if (down_valid && down_ready) begin
            emitted++;
            if (q.size() == 0) begin
               chk("spurious_result", 1, 0);
            end else begin
               r = q.pop_front();
               chk("sb_diff", int'(diff), r.d);
               chk("sb_sat", int'(sat), r.s);
            end
         end
         if (up_valid && up_ready) begin
            q.push_back(model(int'(a), int'(b)));
            accepted++;
         end
         hold   = down_valid && !down_ready;
         hold_d = int'(diff);
         hold_s = int'(sat);
      end
      @(posedge clk);
      #1;
   endtask

   vec_t tbl[9];
   vec_t bp[4];
   vec_t sv[5];

   initial begin
      int base_a, base_e, cyc;

      tbl[0] = '{3, 1, 2, 0};    tbl[1] = '{1, -2, 3, 0};
      tbl[2] = '{-1, 2, -3, 0};  tbl[3] = '{-3, -5, 2, 0};
      tbl[4] = '{7, -4, 7, 1};   tbl[5] = '{-7, 4, -8, 1};
      tbl[6] = '{0, -8, 7, 1};   tbl[7] = '{-8, -8, 0, 0};
      tbl[8] = '{-8, 1, -8, 1};
      bp[0]  = '{5, 2, 3, 0};    bp[1]  = '{-3, 4, -7, 0};
      bp[2]  = '{6, -1, 7, 0};   bp[3]  = '{-8, -8, 0, 0};
      sv[0]  = '{7, -4, 7, 1};   sv[1]  = '{-7, 4, -8, 1};
      sv[2]  = '{0, -8, 7, 1};   sv[3]  = '{-8, 1, -8, 1};
      sv[4]  = '{7, -8, 7, 1};

      rst_n = 1'b0; up_valid = 1'b0; down_ready = 1'b0; a = '0; b = '0;
      #1;
      chk("reset_down_valid", int'(down_valid), 0);
      chk("reset_diff", int'(diff), 0);
      chk("reset_sat", int'(sat), 0);
      chk("reset_up_ready", int'(up_ready), 1);
`ifdef SIGNED_SUB_SAT_COUNT_EN
      chk("reset_sat_count", int'(sat_count), 0);
`endif
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Streaming table: each result exactly two cycles after its presentation cycle.
      for (int c = 0; c < 11; c++) begin
         down_ready = 1'b1;
         up_valid   = (c < 9);
         if (c < 9) begin a = W'(tbl[c].a); b = W'(tbl[c].b); end
         @(negedge clk);
         chk("stream_up_ready", int'(up_ready), 1);
         if (c >= 2) begin
            chk("stream_valid", int'(down_valid), 1);
            chk("stream_diff", int'(diff), tbl[c-2].d);
            chk("stream_sat", int'(sat), tbl[c-2].s);
         end else begin
            chk("stream_valid_early", int'(down_valid), 0);
         end
         @(posedge clk);
         #1;
      end
      up_valid = 1'b0;
      @(negedge clk);
      chk("stream_drained", int'(down_valid), 0);
      @(posedge clk);
      #1;

      // Backpressure: only two pairs fit while the consumer stalls.
      hold = 1'b0; base_a = accepted; base_e = emitted;
      down_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         up_valid = 1'b1;
         a = W'(bp[accepted - base_a].a); b = W'(bp[accepted - base_a].b);
         tick();
      end
      chk("bp_accepted", accepted - base_a, 2);
      @(negedge clk);
      chk("bp_up_ready_low", int'(up_ready), 0);
      chk("bp_held_diff", int'(diff), bp[0].d);
      @(posedge clk);
      #1;
      down_ready = 1'b1;
      cyc = 0;
      while ((emitted - base_e < 4) && cyc < 20) begin
         up_valid = (accepted - base_a < 4);
         if (up_valid) begin
            a = W'(bp[accepted - base_a].a); b = W'(bp[accepted - base_a].b);
         end
         tick();
         cyc++;
      end
      chk("bp_emitted", emitted - base_e, 4);
      chk("bp_queue_empty", q.size(), 0);

      // Random valid/ready toggling against the queue-based model.
      base_a = accepted; base_e = emitted; cyc = 0;
      while ((emitted - base_e < 1000) && cyc < 30000) begin
         up_valid   = (accepted - base_a < 1000) && (($urandom % 4) != 0);
         a          = W'($urandom);
         b          = W'($urandom);
         down_ready = (($urandom % 3) != 0);
         tick();
         cyc++;
      end
      chk("rand_accepted", accepted - base_a, 1000);
      chk("rand_emitted", emitted - base_e, 1000);

      // Reset with two pairs in flight.
      hold = 1'b0; down_ready = 1'b0;
      up_valid = 1'b1; a = W'(5); b = W'(-4);
      tick();
      a = W'(-6); b = W'(3);
      tick();
      up_valid = 1'b0;
      tick();
      chk("pre_reset_valid", int'(down_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_down_valid", int'(down_valid), 0);
      chk("midrst_diff", int'(diff), 0);
      chk("midrst_sat", int'(sat), 0);
      chk("midrst_up_ready", int'(up_ready), 1);
`ifdef SIGNED_SUB_SAT_COUNT_EN
      chk("midrst_sat_count", int'(sat_count), 0);
`endif
      q.delete();
      hold = 1'b0;
      down_ready = 1'b1;
      @(negedge clk);
      chk("inrst_down_valid", int'(down_valid), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("postrst_no_stale", int'(down_valid), 0);
      end

`ifdef SIGNED_SUB_SAT_COUNT_EN
      // Two-bit counter saturates at 3.
      for (int c = 0; c < 8; c++) begin
         down_ready = 1'b1;
         up_valid   = (c < 5);
         if (c < 5) begin a = W'(sv[c].a); b = W'(sv[c].b); end
         @(negedge clk);
         if (c >= 3) chk("sat_count", int'(sat_count), (c - 2 > 3) ? 3 : c - 2);
         @(posedge clk);
         #1;
      end
      up_valid = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
